// File: rtl/mem_io_responder_pkg.sv
// Shared constants, defaults and the I/O address decoder for the memory/I/O responder.
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_SEL    = 2'b11;
  localparam logic [31:0] ADDR_UART = 32'h0003_0000;
  localparam logic [31:0] ADDR_CLK  = 32'h0003_0004;

  localparam int DEF_RAM_ADDR_WIDTH = 17;
  localparam int DEF_TXQ_DEPTH      = 8;
  localparam int DEF_RXQ_DEPTH      = 8;

  typedef enum logic [2:0] {
    IO_NONE,
    IO_UART,
    IO_CLK0,
    IO_CLK1,
    IO_CLK2,
    IO_CLK3
  } io_sel_e;

  // Exact-match decode of the I/O registers; anything else is IO_NONE.
  function automatic io_sel_e io_decode(input logic [31:0] addr);
    io_sel_e sel;
    case (addr)
      ADDR_UART:          sel = IO_UART;
      ADDR_CLK:           sel = IO_CLK0;
      ADDR_CLK + 32'd1:   sel = IO_CLK1;
      ADDR_CLK + 32'd2:   sel = IO_CLK2;
      ADDR_CLK + 32'd3:   sel = IO_CLK3;
      default:            sel = IO_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU bus, UART TX/RX streams and status flags of the memory/I/O responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop, tx_overflow
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder_sync_byte_fifo.sv
// Single-clock byte FIFO; a push while full is accepted only when a pop happens in the same cycle.
module sync_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // Control state; reset empties the FIFO and drops anything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage, no reset needed since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/mem_io_responder.sv
// CPU memory responder: byte RAM plus UART FIFOs, cycle counter and stop flag on the I/O page.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int TXQ_DEPTH      = DEF_TXQ_DEPTH,
  parameter int RXQ_DEPTH      = DEF_RXQ_DEPTH
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  logic [7:0] ram_mem [2**RAM_ADDR_WIDTH];

  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      is_io;
  io_sel_e                   io_sel;

  logic [7:0]  mem_din_q, mem_din_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        program_stop_q, program_stop_d;
  logic        tx_overflow_q, tx_overflow_d;

  logic       tx_push, tx_full, tx_empty;
  logic [7:0] tx_din, tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  assign is_io   = (bus.mem_a[17:16] == IO_SEL);
  assign io_sel  = io_decode(bus.mem_a);
  assign ram_idx = bus.mem_a[RAM_ADDR_WIDTH-1:0];

  // A stop write also emits a 0x00 byte so the host side sees the end of output.
  assign tx_push = bus.mem_wr &&
                   (((io_sel == IO_UART) && (bus.mem_dout != 8'h00)) || (io_sel == IO_CLK0));
  assign tx_din  = (io_sel == IO_CLK0) ? 8'h00 : bus.mem_dout;

  assign rx_push = bus.rx_valid && !rx_full;
  assign rx_pop  = !bus.mem_wr && (io_sel == IO_UART);

  sync_byte_fifo #(.DEPTH(TXQ_DEPTH)) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (tx_push),
    .data_i  (tx_din),
    .pop_i   (bus.tx_ready),
    .data_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  sync_byte_fifo #(.DEPTH(RXQ_DEPTH)) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (rx_push),
    .data_i  (bus.rx_data),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // Read mux, snapshot latch, sticky flags and free-running counter next state.
  always_comb begin
    mem_din_d      = mem_din_q;
    cnt_d          = cnt_q + 32'd1;
    snap_d         = snap_q;
    program_stop_d = program_stop_q;
    tx_overflow_d  = tx_overflow_q;
    if (!bus.mem_wr) begin
      case (io_sel)
        IO_UART: mem_din_d = rx_empty ? 8'h00 : rx_head;
        IO_CLK0: begin
          mem_din_d = cnt_q[7:0];
          snap_d    = cnt_q;
        end
        IO_CLK1: mem_din_d = snap_q[15:8];
        IO_CLK2: mem_din_d = snap_q[23:16];
        IO_CLK3: mem_din_d = snap_q[31:24];
        default: mem_din_d = is_io ? 8'h00 : ram_mem[ram_idx];
      endcase
    end else if (io_sel == IO_CLK0) begin
      program_stop_d = 1'b1;
    end
    // When full the FIFO is non-empty, so tx_ready alone decides whether the push fits.
    if (tx_push && tx_full && !bus.tx_ready) tx_overflow_d = 1'b1;
  end

  // Registered outputs and control state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din_q      <= 8'h00;
      cnt_q          <= 32'h0;
      snap_q         <= 32'h0;
      program_stop_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      mem_din_q      <= mem_din_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
      program_stop_q <= program_stop_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (bus.mem_wr && !is_io) ram_mem[ram_idx] <= bus.mem_dout;
  end

  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = tx_full;
  assign bus.tx_data        = tx_head;
  assign bus.tx_valid       = !tx_empty;
  assign bus.rx_ready       = !rx_full;
  assign bus.program_stop   = program_stop_q;
  assign bus.tx_overflow    = tx_overflow_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: RAM vector table, read-data and TX-byte scoreboards, I/O corner sequences.
module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];
  logic [31:0] cyc_cnt;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles since reset release, tracking the expected counter value.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cyc_cnt <= 32'h0;
    else        cyc_cnt <= cyc_cnt + 32'd1;
  end

  // TX stream scoreboard: every handshake pops one expected byte.
  always @(negedge clk_in) begin
    if (!rst_in && bus.tx_valid && bus.tx_ready) begin
      if (tx_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_extra: got 0x%0h expected no byte", bus.tx_data);
      end else begin
        check("tx_byte", {24'h0, bus.tx_data}, {24'h0, tx_exp_q.pop_front()});
      end
    end
  end

  // One bus cycle; checked reads queue their expectation and are compared once mem_din is valid.
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                     input logic chk, input logic [7:0] exp, input string name);
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
    if (!wr && chk) begin
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
    end
    @(posedge clk_in);
    #1;
    if (rd_exp_q.size() > 0)
      check(rd_name_q.pop_front(), {24'h0, bus.mem_din}, {24'h0, rd_exp_q.pop_front()});
  endtask

  task automatic idle();
    cyc(32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, "");
  endtask

  task automatic drain_tx();
    for (int k = 0; k < 50 && (bus.tx_valid || tx_exp_q.size() != 0); k++) idle();
    check("tx_drain_pending", tx_exp_q.size(), 0);
    check("tx_valid_idle", {31'h0, bus.tx_valid}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;

    vt[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00};
    vt[1]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
    vt[2]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00};
    vt[3]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C};
    vt[4]  = '{32'h0000_0000, 1'b1, 8'h77, 1'b0, 8'h00};
    vt[5]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h77};
    vt[6]  = '{32'h0002_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
    vt[7]  = '{32'h0001_0010, 1'b1, 8'h11, 1'b0, 8'h00};
    vt[8]  = '{32'h0003_0010, 1'b1, 8'h99, 1'b0, 8'h00};
    vt[9]  = '{32'h0001_0010, 1'b0, 8'h00, 1'b1, 8'h11};
    vt[10] = '{32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h00};
    vt[11] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
    vt[12] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00};
    vt[13] = '{32'h0003_0007, 1'b0, 8'h00, 1'b1, 8'h00};
    vt[14] = '{32'h0000_0010, 1'b1, 8'h5A, 1'b0, 8'h00};
    vt[15] = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h5A};
    vt[16] = '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00};
    vt[17] = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5};

    bus.mem_a    = 32'h0000_0100;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    #2 rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_mem_din", {24'h0, bus.mem_din}, 0);
    check("rst_program_stop", {31'h0, bus.program_stop}, 0);
    check("rst_tx_overflow", {31'h0, bus.tx_overflow}, 0);
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 0);
    check("rst_rx_ready", {31'h0, bus.rx_ready}, 1);
    check("rst_io_buffer_full", {31'h0, bus.io_buffer_full}, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // RAM and plain I/O vectors
    for (int i = 0; i < 18; i++) cyc(vt[i].a, vt[i].wr, vt[i].d, vt[i].chk, vt[i].exp, $sformatf("vec%0d", i));
    check("io_write_no_tx", {31'h0, bus.tx_valid}, 0);

    // TX stream with a zero byte in the middle
    bus.tx_ready = 1'b1;
    tx_exp_q.push_back(8'h41);
    tx_exp_q.push_back(8'h42);
    cyc(ADDR_UART, 1'b1, 8'h41, 1'b0, 8'h00, "");
    cyc(ADDR_UART, 1'b1, 8'h00, 1'b0, 8'h00, "");
    cyc(ADDR_UART, 1'b1, 8'h42, 1'b0, 8'h00, "");
    drain_tx();

    // TX fill to full, simultaneous push/pop at full, then overflow
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_not_full_%0d", i), {31'h0, bus.io_buffer_full}, 0);
      tx_exp_q.push_back(8'h55);
      cyc(ADDR_UART, 1'b1, 8'h55, 1'b0, 8'h00, "");
    end
    check("tx_full_after_8", {31'h0, bus.io_buffer_full}, 1);
    check("tx_no_overflow_yet", {31'h0, bus.tx_overflow}, 0);
    bus.tx_ready = 1'b1;
    tx_exp_q.push_back(8'h66);
    cyc(ADDR_UART, 1'b1, 8'h66, 1'b0, 8'h00, "");
    check("tx_full_push_pop", {31'h0, bus.io_buffer_full}, 1);
    check("tx_push_pop_no_ovf", {31'h0, bus.tx_overflow}, 0);
    bus.tx_ready = 1'b0;
    cyc(ADDR_UART, 1'b1, 8'h55, 1'b0, 8'h00, "");
    check("tx_overflow_set", {31'h0, bus.tx_overflow}, 1);
    check("tx_full_after_drop", {31'h0, bus.io_buffer_full}, 1);
    bus.tx_ready = 1'b1;
    drain_tx();
    check("tx_overflow_sticky", {31'h0, bus.tx_overflow}, 1);
    check("tx_not_full_drained", {31'h0, bus.io_buffer_full}, 0);

    // Cycle counter: live byte 0, then coherent snapshot bytes later
    for (int i = 0; i < 600; i++) idle();
    snap = cyc_cnt;
    cyc(ADDR_CLK, 1'b0, 8'h00, 1'b1, snap[7:0], "clk_byte0");
    idle();
    idle();
    cyc(ADDR_CLK + 32'd1, 1'b0, 8'h00, 1'b1, snap[15:8], "clk_byte1");
    cyc(ADDR_CLK + 32'd2, 1'b0, 8'h00, 1'b1, snap[23:16], "clk_byte2");
    idle();
    cyc(ADDR_CLK + 32'd3, 1'b0, 8'h00, 1'b1, snap[31:24], "clk_byte3");
    for (int i = 0; i < 37; i++) idle();
    snap = cyc_cnt;
    cyc(ADDR_CLK, 1'b0, 8'h00, 1'b1, snap[7:0], "clk2_byte0");
    cyc(ADDR_CLK + 32'd1, 1'b0, 8'h00, 1'b1, snap[15:8], "clk2_byte1");

    // RX single byte, then the empty-FIFO read
    bus.rx_data  = 8'h31;
    bus.rx_valid = 1'b1;
    idle();
    bus.rx_valid = 1'b0;
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h31, "rx_read_31");
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h00, "rx_read_empty");

    // RX push and CPU pop together on an empty FIFO: no forwarding
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h00, "rx_no_forward");
    bus.rx_valid = 1'b0;
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h5A, "rx_after_forward");
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h00, "rx_empty_again");

    // RX fill to full; the ninth byte is refused
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("rx_ready_%0d", i), {31'h0, bus.rx_ready}, (i < 8) ? 1 : 0);
      bus.rx_data = 8'(8'h80 + i);
      idle();
    end
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'(8'h80 + i), $sformatf("rx_fill_%0d", i));
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h00, "rx_fill_drop");
    check("rx_ready_drained", {31'h0, bus.rx_ready}, 1);

    // Stop write emits 0x00 and latches program_stop
    bus.tx_ready = 1'b1;
    tx_exp_q.push_back(8'h00);
    cyc(ADDR_CLK, 1'b1, 8'h12, 1'b0, 8'h00, "");
    check("program_stop_set", {31'h0, bus.program_stop}, 1);
    drain_tx();
    check("program_stop_sticky", {31'h0, bus.program_stop}, 1);

    // Load both FIFOs and a read result, then reset mid-stream
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hC3;
    for (int i = 0; i < 8; i++) cyc(ADDR_UART, 1'b1, 8'h44, 1'b0, 8'h00, "");
    bus.rx_valid = 1'b0;
    check("pre_rst_tx_full", {31'h0, bus.io_buffer_full}, 1);
    check("pre_rst_rx_full", {31'h0, bus.rx_ready}, 0);
    cyc(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5, "pre_rst_read");
    rst_in = 1'b1;
    #1;
    check("arst_mem_din", {24'h0, bus.mem_din}, 0);
    check("arst_program_stop", {31'h0, bus.program_stop}, 0);
    check("arst_tx_overflow", {31'h0, bus.tx_overflow}, 0);
    check("arst_tx_valid", {31'h0, bus.tx_valid}, 0);
    check("arst_rx_ready", {31'h0, bus.rx_ready}, 1);
    check("arst_io_buffer_full", {31'h0, bus.io_buffer_full}, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    cyc(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_kept_after_rst");
    cyc(ADDR_CLK + 32'd1, 1'b0, 8'h00, 1'b1, 8'h00, "snap_cleared");
    cyc(ADDR_UART, 1'b0, 8'h00, 1'b1, 8'h00, "rx_cleared");
    check("post_rst_tx_valid", {31'h0, bus.tx_valid}, 0);
    check("post_rst_program_stop", {31'h0, bus.program_stop}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, giving a RAM of 2^17 bytes (valid addresses 0x00000-0x1FFFF).
REQ-002 SHALL have parameter TXQ_DEPTH, default 8, giving the UART-TX byte FIFO depth (power of 2).
REQ-003 SHALL have parameter RXQ_DEPTH, default 8, giving the UART-RX byte FIFO depth (power of 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports: clk_in input 1, clock; rst_in input 1, async active-high reset.
REQ-005 Port mem_a, input, 32 bits: byte address from the CPU, driven every cycle.
REQ-006 Port mem_dout, input, 8 bits: write data from the CPU.
REQ-007 Port mem_wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port mem_din, output, 8 bits: read data to the CPU.
REQ-009 Port io_buffer_full, output, 1 bit: TX FIFO full.
REQ-010 Port tx_data, output, 8 bits; port tx_valid, output, 1 bit; port tx_ready, input, 1 bit: UART TX stream.
REQ-011 Port rx_data, input, 8 bits; port rx_valid, input, 1 bit; port rx_ready, output, 1 bit: UART RX stream.
REQ-012 Port program_stop, output, 1 bit: sticky end-of-program flag.
REQ-013 Port tx_overflow, output, 1 bit: sticky flag, set by a write to a full TX FIFO.

Function
REQ-014 SHALL decode I/O when mem_a[17:16]==2'b11; all other addresses SHALL access RAM at index mem_a[RAM_ADDR_WIDTH-1:0].
REQ-015 RAM write: when mem_wr=1 in cycle N, the RAM byte SHALL be updated at the clock edge ending cycle N.
REQ-016 Read latency: mem_din SHALL present the cycle-N read result throughout cycle N+1; mem_din SHALL be a registered output.
REQ-017 Read-after-write to the same address in consecutive cycles SHALL return the new data.
REQ-018 Read of 0x30000 with the RX FIFO non-empty SHALL return the head byte and pop it in the same edge.
REQ-019 Read of 0x30000 with the RX FIFO empty SHALL return 0x00 and SHALL NOT pop.
REQ-020 Cycle counter: a 32-bit counter SHALL increment every cycle after reset and wrap 0xFFFFFFFF->0.
REQ-021 Read of 0x30004 SHALL return byte 0 of the live counter and snapshot the counter into a 32-bit latch.
REQ-022 Reads of 0x30005, 0x30006 and 0x30007 SHALL return bytes 1, 2 and 3 of the snapshot latch (little-endian, coherent dword).
REQ-023 Write of 0x30000 with a nonzero byte SHALL push that byte to the TX FIFO; a write of 0x00 SHALL be ignored.
REQ-024 Write of 0x30004 SHALL set program_stop and push 0x00 to the TX FIFO; program_stop SHALL stay set until reset.
REQ-025 Other I/O addresses: reads SHALL return 0x00; writes SHALL be ignored.
REQ-026 io_buffer_full SHALL be combinational from the registered TX count and SHALL equal (count==TXQ_DEPTH).
REQ-027 A TX push while full SHALL be dropped and SHALL set tx_overflow (sticky).
REQ-028 TX drain: tx_valid = FIFO not empty; tx_data = head byte; a pop occurs on tx_valid && tx_ready.
REQ-029 A simultaneous TX push and pop when full SHALL be accepted, with the count unchanged.
REQ-030 RX fill: rx_ready = RX FIFO not full; a push occurs on rx_valid && rx_ready.
REQ-031 A simultaneous RX push and CPU pop on an empty FIFO SHALL NOT forward the byte; that read returns 0x00.
REQ-032 FIFO pointers SHALL wrap modulo depth; each FIFO count SHALL be log2(depth)+1 bits wide.

Reset
REQ-033 On reset assertion the block SHALL immediately clear to: mem_din=0, counter=0, snapshot=0, both FIFOs empty, program_stop=0, tx_overflow=0, tx_valid=0, rx_ready=1, io_buffer_full=0.
REQ-034 Reset SHALL NOT clear RAM contents.
REQ-035 Reset mid-access SHALL discard any pending read result and any in-flight FIFO operation.

Structure
REQ-036 A shared package SHALL hold IO_SEL=2'b11, ADDR_UART=0x30000, ADDR_CLK=0x30004, and the default depths.
REQ-037 SHALL instantiate sub-module sync_byte_fifo (parameter DEPTH) twice, once for TX and once for RX.
REQ-038 RAM SHALL be inferred as a single-port byte array with a registered read.

Verification
REQ-039 Write 0xA5 to 0x00010, then read 0x00010 in the next cycle -> mem_din=0xA5 one cycle later.
REQ-040 Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx stream 0x41, 0x42 only.
REQ-041 With tx_ready=0, perform 9 writes of 0x55 to 0x30000 -> io_buffer_full=1 after the 8th; the 9th is dropped; tx_overflow=1.
REQ-042 Counter=0x12345678 at the 0x30004 read, then read 0x30005-0x30007 over the following cycles -> 0x78, 0x56, 0x34, 0x12.
REQ-043 Push 0x31 via rx_valid, then read 0x30000 twice -> 0x31, then 0x00.
REQ-044 Write to 0x30004 -> program_stop=1 and tx_data=0x00 emitted; assert reset -> program_stop=0, RAM byte at 0x00010 still 0xA5.
